// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and
// width helpers used by both the top level and the combinational unit.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NAND   = 4'd5;
    localparam logic [3:0] OP_NOR    = 4'd6;
    localparam logic [3:0] OP_XNOR   = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_ROL    = 4'd11;
    localparam logic [3:0] OP_PASS_A = 4'd12;
    localparam logic [3:0] OP_NOT_A  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int shw_for(input int width);
        return $clog2(width);
    endfunction

    // Opcodes 8..11 are the iterative shifts.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle arithmetic/logic operations; shift opcodes produce zeros here
// because the top level handles them iteratively.
module alu_comb_unit
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = sum_add[WIDTH-1:0];
                carry    = sum_add[WIDTH];
                overflow = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result   = sum_sub[WIDTH-1:0];
                carry    = sum_sub[WIDTH];
                overflow = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
            end
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XNOR:   result = ~(a ^ b);
            OP_PASS_A: result = a;
            OP_NOT_A:  result = ~a;
            OP_SLL, OP_SRL, OP_SRA, OP_ROL: result = '0;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with handshaked request/result and a one-bit-per-cycle shifter.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_SHIFT | shifting OUT by one bit per cycle until the count reaches 1
//   ST_DONE  | result valid, held until out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHW = shw_for(WIDTH);

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic [SHW-1:0]   amt;
    logic             load;
    logic             shift_en;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_illegal;

    logic [WIDTH-1:0] sh_nxt;
    logic             sh_bit;

    assign amt = B[SHW-1:0];

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .a        (A),
        .b        (B),
        .opcode   (opcode),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_ovf),
        .illegal  (alu_illegal)
    );

    // OUT doubles as the shift register while in ST_SHIFT.
    always_comb begin
        sh_nxt = {OUT[WIDTH-2:0], 1'b0};
        sh_bit = OUT[WIDTH-1];
        case (op_q)
            OP_SRL: begin
                sh_nxt = {1'b0, OUT[WIDTH-1:1]};
                sh_bit = OUT[0];
            end
            OP_SRA: begin
                sh_nxt = {OUT[WIDTH-1], OUT[WIDTH-1:1]};
                sh_bit = OUT[0];
            end
            OP_ROL: begin
                sh_nxt = {OUT[WIDTH-2:0], OUT[WIDTH-1]};
                sh_bit = OUT[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                    if (is_shift_op(opcode) && (amt != '0)) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt_q    <= '0;
            OUT      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            illegal  <= 1'b0;
        end else if (load) begin
            op_q <= opcode;
            if (is_shift_op(opcode)) begin
                OUT      <= A;
                cnt_q    <= amt;
                carry    <= 1'b0;
                overflow <= 1'b0;
                illegal  <= 1'b0;
                zero     <= (A == '0);
                negative <= A[WIDTH-1];
            end else begin
                OUT      <= alu_result;
                cnt_q    <= '0;
                carry    <= alu_carry;
                overflow <= alu_ovf;
                illegal  <= alu_illegal;
                zero     <= (alu_result == '0);
                negative <= alu_result[WIDTH-1];
            end
        end else if (shift_en) begin
            OUT      <= sh_nxt;
            carry    <= sh_bit;
            cnt_q    <= cnt_q - SHW'(1);
            zero     <= (sh_nxt == '0);
            negative <= sh_nxt[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] A, B;
    logic [3:0] opcode;
    logic       in_valid, in_ready;
    logic [7:0] OUT;
    logic       carry, overflow, zero, negative, illegal;
    logic       out_valid, out_ready;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OUT       (OUT),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .illegal   (illegal),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns one cycle after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        A        = a;
        B        = b;
        opcode   = op;
        in_valid = 1'b1;
        chk("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle until out_valid, bounded.
    task automatic wait_valid(output int lat, output logic saw_ready);
        lat       = 1;
        saw_ready = in_ready;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
            if (!out_valid) saw_ready = saw_ready | in_ready;
        end
    endtask

    task automatic xfer();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("xfer_valid_drop", out_valid, 1'b0);
        chk("xfer_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic saw_ready;

        rst_n     = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #22;
        chk("rst_out", OUT, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_flags", {carry, overflow, zero, negative, illegal}, 5'b00000);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1'b1);
        step();
        chk("idle_valid", out_valid, 1'b0);

        // ADD 7F+01
        issue(8'h7F, 8'h01, 4'd0);
        chk("add_lat1", out_valid, 1'b1);
        chk("add_out", OUT, 8'h80);
        chk("add_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b01010);
        xfer();

        // SUB 05-05
        issue(8'h05, 8'h05, 4'd1);
        chk("sub_lat1", out_valid, 1'b1);
        chk("sub_out", OUT, 8'h00);
        chk("sub_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b10100);
        xfer();

        // XOR F0^3C
        issue(8'hF0, 8'h3C, 4'd4);
        chk("xor_out", OUT, 8'hCC);
        chk("xor_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b00010);
        xfer();

        // SRA 90 by 3, inputs scrambled after accept
        issue(8'h90, 8'h03, 4'd10);
        A = 8'hFF;
        B = 8'h00;
        opcode = 4'd0;
        wait_valid(lat, saw_ready);
        chk("sra_lat", lat, 4);
        chk("sra_ready_low", saw_ready, 1'b0);
        chk("sra_out", OUT, 8'hF2);
        chk("sra_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b00010);
        xfer();

        // SLL with zero shift amount: pass-through, latency 1
        issue(8'h5A, 8'h08, 4'd8);
        chk("sll0_lat1", out_valid, 1'b1);
        chk("sll0_out", OUT, 8'h5A);
        chk("sll0_carry", carry, 1'b0);
        xfer();

        // ROL 81 by 1, then back-pressure with a competing request
        issue(8'h81, 8'h01, 4'd11);
        wait_valid(lat, saw_ready);
        chk("rol_lat", lat, 2);
        chk("rol_out", OUT, 8'h03);
        chk("rol_carry", carry, 1'b1);
        A        = 8'h55;
        B        = 8'h22;
        opcode   = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_out", OUT, 8'h03);
            chk("hold_flags", {carry, overflow, zero, negative, illegal}, 5'b10000);
            chk("hold_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        xfer();
        step();
        chk("no_extra_result", out_valid, 1'b0);

        // Illegal opcode 14
        issue(8'h3C, 8'h11, 4'd14);
        chk("ill_lat1", out_valid, 1'b1);
        chk("ill_out", OUT, 8'h00);
        chk("ill_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b00101);
        xfer();

        // SLL 01 by 7, reset during the third shift cycle
        issue(8'h01, 8'h07, 4'd8);
        step();
        step();
        chk("sll_mid_out", OUT, 8'h04);
        chk("sll_mid_valid", out_valid, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_out", OUT, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready", in_ready, 1'b1);
        saw_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            saw_ready = saw_ready | out_valid;
        end
        chk("abort_no_stale", saw_ready, 1'b0);

        // Normal operation resumes: 01+FF wraps to zero with carry
        issue(8'h01, 8'hFF, 4'd0);
        chk("post_lat1", out_valid, 1'b1);
        chk("post_out", OUT, 8'h00);
        chk("post_flags_cvznI", {carry, overflow, zero, negative, illegal}, 5'b10100);
        xfer();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
